// File: rtl/fifo_256_40bit_ctrl_pkg.sv
// Shared constants, controller state encoding and helpers for the fifo_256_40bit controller.
package fifo_256_40bit_ctrl_pkg;

    localparam int unsigned FIFO_DW = 40;
    localparam int unsigned FIFO_AW = 8;

    typedef enum logic {
        StRun   = 1'b0,
        StFlush = 1'b1
    } ctrl_state_e;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_out_skid2.sv
// Two-entry output skid buffer: head is always presented, push lands at the tail.
module fifo_out_skid2
    import fifo_256_40bit_ctrl_pkg::*;
#(
    parameter int unsigned DW = FIFO_DW
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          clear,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic [1:0]    cnt
);

    logic [DW-1:0] head_q, head_d;
    logic [DW-1:0] tail_q, tail_d;
    logic [1:0]    cnt_q, cnt_d;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (clear) begin
            cnt_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) begin
                        head_d = din;
                    end else begin
                        tail_d = din;
                    end
                    cnt_d = cnt_q + 2'd1;
                end
                2'b01: begin
                    head_d = tail_q;
                    cnt_d  = cnt_q - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; with one entry the new word becomes the head.
                    if (cnt_q == 2'd1) begin
                        head_d = din;
                    end else begin
                        head_d = tail_q;
                        tail_d = din;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    assign dout = head_q;
    assign cnt  = cnt_q;

    no_overflow_a: assert property (@(posedge clk) disable iff (!resetn)
        !(push && !pop && !clear && cnt_q == 2'd2));

endmodule

// File: rtl/fifo_256_40bit_ctrl.sv
// Arbitrates NREQ writers into one fifo_256_40bit and streams its read side through a skid.
module fifo_256_40bit_ctrl
    import fifo_256_40bit_ctrl_pkg::*;
#(
    parameter  int unsigned NREQ = 4,
    parameter  int unsigned DW   = FIFO_DW,
    parameter  int unsigned AW   = FIFO_AW,
    localparam int unsigned GW   = clog2(NREQ)
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]    req_ready,
    input  logic               flush,
    output logic               fifo_we,
    output logic [DW-1:0]      fifo_din,
    output logic               fifo_re,
    output logic               fifo_clr,
    input  logic [DW-1:0]      fifo_dout,
    input  logic               fifo_full,
    input  logic               fifo_empty,
    output logic               out_valid,
    output logic [DW-1:0]      out_data,
    input  logic               out_ready,
    output logic [AW:0]        count,
    output logic [GW-1:0]      last_grant
);

    localparam logic [AW:0] CountOne = (AW + 1)'(1);

    ctrl_state_e   state_q, state_d;
    logic [GW-1:0] rr_ptr_q, rr_ptr_d;
    logic [GW-1:0] last_grant_q, last_grant_d;
    logic          inflight_q, inflight_d;
    logic [AW:0]   count_q, count_d;

    logic [DW-1:0] req_word [NREQ];
    logic          run;
    logic          grant_found;
    logic [GW-1:0] grant_idx;
    int unsigned   idx;
    logic [1:0]    skid_cnt;
    logic          skid_push;
    logic          skid_pop;
    logic          skid_clear;

    for (genvar g = 0; g < NREQ; g++) begin : g_req_word
        assign req_word[g] = req_data[g*DW +: DW];
    end

    // Handshakes are gated by resetn so outputs read zero for the whole reset interval.
    assign run = resetn && (state_q == StRun) && !flush;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = (32'(rr_ptr_q) + i) % NREQ;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = GW'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        fifo_we   = run && !fifo_full && grant_found;
        fifo_din  = '0;
        if (fifo_we) begin
            req_ready[grant_idx] = 1'b1;
            fifo_din             = req_word[grant_idx];
        end
    end

    // At most two words may be owned downstream of the FIFO: skid entries plus the pending read.
    assign fifo_re = run && !fifo_empty &&
                     (({1'b0, skid_cnt} + {2'b00, inflight_q}) < 3'd2);

    assign fifo_clr   = resetn && (state_q == StFlush);
    assign out_valid  = (state_q == StRun) && (skid_cnt != 2'd0);
    assign skid_push  = inflight_q && run;
    assign skid_pop   = out_valid && out_ready;
    assign skid_clear = (state_q == StRun) && flush;

    fifo_out_skid2 #(
        .DW (DW)
    ) u_skid (
        .clk    (clk),
        .resetn (resetn),
        .clear  (skid_clear),
        .push   (skid_push),
        .din    (fifo_dout),
        .pop    (skid_pop),
        .dout   (out_data),
        .cnt    (skid_cnt)
    );

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        last_grant_d = last_grant_q;
        inflight_d   = fifo_re;
        count_d      = count_q;
        unique case (state_q)
            StRun: begin
                if (flush) begin
                    state_d = StFlush;
                    count_d = '0;
                end else begin
                    if (fifo_we) begin
                        rr_ptr_d     = (grant_idx == GW'(NREQ - 1)) ? '0 : grant_idx + GW'(1);
                        last_grant_d = grant_idx;
                    end
                    if (fifo_we && !fifo_re) begin
                        count_d = count_q + CountOne;
                    end else if (fifo_re && !fifo_we) begin
                        count_d = count_q - CountOne;
                    end
                end
            end
            StFlush: begin
                state_d = StRun;
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StRun;
            rr_ptr_q     <= '0;
            last_grant_q <= '0;
            inflight_q   <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            last_grant_q <= last_grant_d;
            inflight_q   <= inflight_d;
            count_q      <= count_d;
        end
    end

    assign count      = count_q;
    assign last_grant = last_grant_q;

endmodule
